// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_pkg
//  Purpose  : Shared definitions for the hazard controller. It holds the FSM
//             state encodings and the default register-index width.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package hazard_ctrl_pkg;

  localparam int REG_W_DEF = 4;

  // FSM state encodings. The values are fixed so that external tools can
  // decode the state.
  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] FLUSH    = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

endpackage : hazard_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_if
//  Purpose  : Bundles the signals exchanged between the pipeline and the
//             hazard controller.
//  Ports    : master - the pipeline side. It drives the ID/EXE/MEM status
//                      and receives the freeze/flush controls.
//             slave  - the controller side (hazard_ctrl).
//  Revision : 1.0  initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] src1;
  logic [REG_W-1:0] src2;
  logic             twoSrc;
  logic             exeWbEn;
  logic [REG_W-1:0] exeDest;
  logic             exeMemRead;
  logic             memWbEn;
  logic [REG_W-1:0] memDest;
  logic             branchTaken;
  logic             memBusy;
  logic             freeze;
  logic             flushIfId;
  logic             bubbleIdEx;
  logic             freezeAll;
  logic             memError;
  logic [CNT_W-1:0] stallCount;

  modport master (
    output src1, src2, twoSrc, exeWbEn, exeDest, exeMemRead,
           memWbEn, memDest, branchTaken, memBusy,
    input  freeze, flushIfId, bubbleIdEx, freezeAll, memError, stallCount
  );

  modport slave (
    input  src1, src2, twoSrc, exeWbEn, exeDest, exeMemRead,
           memWbEn, memDest, branchTaken, memBusy,
    output freeze, flushIfId, bubbleIdEx, freezeAll, memError, stallCount
  );
endinterface : hazard_ctrl_if
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Up-counter that stops at all-ones instead of wrapping.
//  Ports    : clk     - rising-edge clock
//             rst     - asynchronous active-high reset (clears to 0)
//             inc_i   - count this cycle
//             count_o - current count value, CNT_W bits
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : ID-stage hazard controller. It produces the following controls:
//               - freeze/bubble signals for RAW hazards,
//               - flush pulses for taken branches,
//               - a whole-pipe freeze while data memory is busy.
//             It also provides a sticky memory-timeout flag and a saturating
//             stall-cycle counter.
//  Ports    : clk - rising-edge clock
//             rst - asynchronous, active-high reset
//             bus - hazard_ctrl_if.slave. Inputs: src1/src2/twoSrc,
//                   exe*/mem* destinations, branchTaken, memBusy.
//                   Outputs: freeze, flushIfId, bubbleIdEx, freezeAll,
//                   memError, stallCount.
//  Config   : FORWARDING_EN. When this macro is defined, the controller
//             stalls only on load-use hazards in EXE.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W        = REG_W_DEF,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;     // flush cycles still to issue
  logic [TW-1:0]    tcnt_q, tcnt_d;     // consecutive memBusy cycles
  logic             pend_q, pend_d;     // branch seen while memory was busy
  logic             merr_q, merr_d;

  logic [REG_W-1:0] s1, s2, ed, md;
  logic             hazard;
  logic             freeze_c, flush_c, bubble_c, freeze_all_c;

  assign s1 = bus.src1;
  assign s2 = bus.src2;
  assign ed = bus.exeDest;
  assign md = bus.memDest;

  // Register 0 gets no special treatment; all REG_W bits are compared.
  always_comb begin
`ifdef FORWARDING_EN
    hazard = bus.exeMemRead & bus.exeWbEn &
             ((ed == s1) | (bus.twoSrc & (ed == s2)));
`else
    hazard = (bus.exeWbEn & (ed == s1)) | (bus.memWbEn & (md == s1)) |
             (bus.twoSrc & ((bus.exeWbEn & (ed == s2)) |
                            (bus.memWbEn & (md == s2))));
`endif
  end

  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    tcnt_d       = '0;
    pend_d       = pend_q;
    freeze_c     = 1'b0;
    flush_c      = 1'b0;
    bubble_c     = 1'b0;
    freeze_all_c = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.memBusy) begin
          freeze_all_c = 1'b1;
          state_d      = MEM_WAIT;
          tcnt_d       = TW'(1);
          if (bus.branchTaken) begin
            pend_d = 1'b1;
          end
        end else if (bus.branchTaken || pend_q) begin
          // A branch that was held back by a memory stall replays here.
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          pend_d   = 1'b0;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = 3'(FLUSH_CYCLES - 1);
          end
        end else if (hazard) begin
          freeze_c = 1'b1;
          bubble_c = 1'b1;
        end
      end

      FLUSH: begin
        if (bus.memBusy) begin
          // Remaining flush cycles are reissued once memory releases.
          freeze_all_c = 1'b1;
          state_d      = MEM_WAIT;
          tcnt_d       = TW'(1);
          pend_d       = 1'b1;
        end else begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          if (bus.branchTaken) begin
            fcnt_d = 3'(FLUSH_CYCLES - 1);
          end else if (fcnt_q <= 3'd1) begin
            fcnt_d  = 3'd0;
            state_d = RUN;
          end else begin
            fcnt_d = fcnt_q - 3'd1;
          end
        end
      end

      MEM_WAIT: begin
        // EXE is frozen, so any branchTaken seen here is stale.
        if (bus.memBusy) begin
          freeze_all_c = 1'b1;
          tcnt_d = (tcnt_q == TW'(MEM_TIMEOUT)) ? tcnt_q : tcnt_q + TW'(1);
        end else begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase

    merr_d = merr_q | (tcnt_d == TW'(MEM_TIMEOUT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      tcnt_q  <= '0;
      pend_q  <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      tcnt_q  <= tcnt_d;
      pend_q  <= pend_d;
      merr_q  <= merr_d;
    end
  end

  // Controls are masked during reset so the outputs read 0 regardless of
  // the input pattern.
  assign bus.freeze     = freeze_c & ~rst;
  assign bus.flushIfId  = flush_c & ~rst;
  assign bus.bubbleIdEx = bubble_c & ~rst;
  assign bus.freezeAll  = freeze_all_c & ~rst;
  assign bus.memError   = merr_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (freeze_c | freeze_all_c),
    .count_o (bus.stallCount)
  );

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Purpose  : Self-checking bench for hazard_ctrl. It uses these settings:
//             FLUSH_CYCLES=2, MEM_TIMEOUT=255.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  hazard_ctrl_if #(.REG_W(4), .CNT_W(16)) bus ();

  hazard_ctrl #(
    .REG_W        (4),
    .FLUSH_CYCLES (2),
    .MEM_TIMEOUT  (255),
    .CNT_W        (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] s1;
    logic [3:0] s2;
    logic       two;
    logic       ewb;
    logic [3:0] ed;
    logic       emr;
    logic       mwb;
    logic [3:0] md;
    logic       br;
    logic       busy;
    logic       frz_full;
    logic       frz_fwd;
    logic       flush;
    logic       fa;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic zero_inputs();
    bus.src1 = '0; bus.src2 = '0; bus.twoSrc = 1'b0;
    bus.exeWbEn = 1'b0; bus.exeDest = '0; bus.exeMemRead = 1'b0;
    bus.memWbEn = 1'b0; bus.memDest = '0;
    bus.branchTaken = 1'b0; bus.memBusy = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    zero_inputs();
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic ef;
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    zero_inputs();

    //        s1    s2    two   ewb   ed    emr   mwb   md    br    busy  full  fwd   fl    fa
    tv[0]  = '{4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[2]  = '{4'd5, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{4'd1, 4'd7, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{4'd2, 4'd7, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{4'd3, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{4'd0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[7]  = '{4'd8, 4'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[9]  = '{4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[10] = '{4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[11] = '{4'd1, 4'd9, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[12] = '{4'd4, 4'd9, 1'b1, 1'b1, 4'd9, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state
    do_reset();
    #1;
    chk("rst freeze", 32'(bus.freeze), 32'd0);
    chk("rst flushIfId", 32'(bus.flushIfId), 32'd0);
    chk("rst bubbleIdEx", 32'(bus.bubbleIdEx), 32'd0);
    chk("rst freezeAll", 32'(bus.freezeAll), 32'd0);
    chk("rst memError", 32'(bus.memError), 32'd0);
    chk("rst stallCount", 32'(bus.stallCount), 32'd0);

    // Combinational vectors, each applied from a fresh RUN state
    for (int i = 0; i < 13; i++) begin
      do_reset();
      bus.src1 = tv[i].s1; bus.src2 = tv[i].s2; bus.twoSrc = tv[i].two;
      bus.exeWbEn = tv[i].ewb; bus.exeDest = tv[i].ed; bus.exeMemRead = tv[i].emr;
      bus.memWbEn = tv[i].mwb; bus.memDest = tv[i].md;
      bus.branchTaken = tv[i].br; bus.memBusy = tv[i].busy;
`ifdef FORWARDING_EN
      ef = tv[i].frz_fwd;
`else
      ef = tv[i].frz_full;
`endif
      #1;
      chk($sformatf("vec%0d freeze", i), 32'(bus.freeze), 32'(ef));
      chk($sformatf("vec%0d flushIfId", i), 32'(bus.flushIfId), 32'(tv[i].flush));
      chk($sformatf("vec%0d bubbleIdEx", i), 32'(bus.bubbleIdEx), 32'(ef | tv[i].flush));
      chk($sformatf("vec%0d freezeAll", i), 32'(bus.freezeAll), 32'(tv[i].fa));
    end

    // Taken branch with FLUSH_CYCLES=2: flush for exactly two cycles
    do_reset();
    bus.branchTaken = 1'b1;
    #1;
    chk("br c0 flushIfId", 32'(bus.flushIfId), 32'd1);
    chk("br c0 freeze", 32'(bus.freeze), 32'd0);
    @(negedge clk);
    bus.branchTaken = 1'b0;
    #1;
    chk("br c1 flushIfId", 32'(bus.flushIfId), 32'd1);
    chk("br c1 bubbleIdEx", 32'(bus.bubbleIdEx), 32'd1);
    @(negedge clk);
    #1;
    chk("br c2 flushIfId", 32'(bus.flushIfId), 32'd0);

    // memBusy for 5 cycles with a branch in the first one
    do_reset();
    bus.memBusy = 1'b1;
    bus.branchTaken = 1'b1;
    #1;
    chk("mb c1 freezeAll", 32'(bus.freezeAll), 32'd1);
    chk("mb c1 flushIfId", 32'(bus.flushIfId), 32'd0);
    @(negedge clk);
    bus.branchTaken = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      #1;
      chk($sformatf("mb c%0d freezeAll", i), 32'(bus.freezeAll), 32'd1);
      @(negedge clk);
    end
    bus.memBusy = 1'b0;
    #1;
    chk("mb drop freezeAll", 32'(bus.freezeAll), 32'd0);
    chk("mb drop flushIfId", 32'(bus.flushIfId), 32'd0);
    chk("mb stallCount", 32'(bus.stallCount), 32'd5);
    @(negedge clk);
    #1;
    chk("mb replay flushIfId", 32'(bus.flushIfId), 32'd1);
    chk("mb replay freeze", 32'(bus.freeze), 32'd0);
    @(negedge clk);
    #1;
    chk("mb replay2 flushIfId", 32'(bus.flushIfId), 32'd1);
    @(negedge clk);
    #1;
    chk("mb done flushIfId", 32'(bus.flushIfId), 32'd0);
    chk("mb final stallCount", 32'(bus.stallCount), 32'd5);

    // Memory timeout
    do_reset();
    bus.memBusy = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      #1;
      if (i == 250) chk("to c250 memError", 32'(bus.memError), 32'd0);
      if (i == 260) chk("to c260 memError", 32'(bus.memError), 32'd1);
      @(negedge clk);
    end
    bus.memBusy = 1'b0;
    #1;
    chk("to stallCount", 32'(bus.stallCount), 32'd300);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("to sticky memError", 32'(bus.memError), 32'd1);
    chk("to freezeAll off", 32'(bus.freezeAll), 32'd0);

    // Asynchronous reset while in FLUSH
    do_reset();
    bus.branchTaken = 1'b1;
    @(negedge clk);
    bus.branchTaken = 1'b0;
    #1;
    chk("ar flush before rst", 32'(bus.flushIfId), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar flushIfId", 32'(bus.flushIfId), 32'd0);
    chk("ar bubbleIdEx", 32'(bus.bubbleIdEx), 32'd0);
    chk("ar freeze", 32'(bus.freeze), 32'd0);
    chk("ar freezeAll", 32'(bus.freezeAll), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ar post flushIfId", 32'(bus.flushIfId), 32'd0);
    @(negedge clk);
    #1;
    chk("ar post2 flushIfId", 32'(bus.flushIfId), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_hazard_ctrl
`default_nettype wire
